// File: rtl/field_read_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// field_sched_pkg
// Shared types and constants for the field read scheduler.
//   sched_state_e      : scheduler FSM encoding (LOAD=0, WAIT=1, STREAM=2, ERR=3)
//   BLANK_WORD_DEFAULT : YCbCr black word output on underflow or outside STREAM
//   LINE_CNT_W         : width of the active line index
// -----------------------------------------------------------------------------
package field_sched_pkg;

    typedef enum logic [1:0] {
        S_LOAD   = 2'd0,
        S_WAIT   = 2'd1,
        S_STREAM = 2'd2,
        S_ERR    = 2'd3
    } sched_state_e;

    localparam logic [15:0] BLANK_WORD_DEFAULT = 16'h8010;
    localparam int          LINE_CNT_W         = 10;

endpackage

// File: rtl/field_read_scheduler_if.sv
// -----------------------------------------------------------------------------
// field_read_scheduler_if
// Bundles the VGA request, the two SDRAM read-FIFO ports and the scheduler
// status outputs.
//   slave  : scheduler side (consumes pix_ready / FIFO data, drives requests)
//   master : environment side (vga_sync + FIFOs)
// Handshake: one pixel word is consumed on every clock where pix_ready is 1.
// rd1_req/rd2_req are combinational in that same clock; the matching word
// appears on pix_data with pix_valid=1 one clock later. There is no
// back-pressure towards the VGA side.
// -----------------------------------------------------------------------------
interface field_read_scheduler_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int UFLOW_WIDTH = 16
);
    import field_sched_pkg::*;

    logic                   pix_ready;
    logic [DATA_WIDTH-1:0]  rd1_data;
    logic                   rd1_empty;
    logic [DATA_WIDTH-1:0]  rd2_data;
    logic                   rd2_empty;
    logic                   rd1_req;
    logic                   rd2_req;
    logic                   rd_load;
    logic                   lb_clken;
    logic [DATA_WIDTH-1:0]  pix_data;
    logic                   pix_valid;
    logic [LINE_CNT_W-1:0]  line_cnt;
    logic [UFLOW_WIDTH-1:0] underflow_cnt;
    logic [1:0]             sched_state;

    modport slave (
        input  pix_ready, rd1_data, rd1_empty, rd2_data, rd2_empty,
        output rd1_req, rd2_req, rd_load, lb_clken, pix_data, pix_valid,
               line_cnt, underflow_cnt, sched_state
    );

    modport master (
        output pix_ready, rd1_data, rd1_empty, rd2_data, rd2_empty,
        input  rd1_req, rd2_req, rd_load, lb_clken, pix_data, pix_valid,
               line_cnt, underflow_cnt, sched_state
    );

endinterface

// File: rtl/field_read_scheduler_raster_counter.sv
// -----------------------------------------------------------------------------
// raster_counter
// Pixel/line position within the active frame.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : one pixel consumed this clock
//   line_cnt_o    : current active line index
//   frame_done_o  : combinational, high on the enabled clock that consumes the
//                   last pixel of the last line (both counters wrap to 0)
// -----------------------------------------------------------------------------
module raster_counter
    import field_sched_pkg::*;
#(
    parameter int H_ACT = 640,
    parameter int V_ACT = 480
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    output logic [LINE_CNT_W-1:0] line_cnt_o,
    output logic                  frame_done_o
);

    localparam int PIX_W = (H_ACT > 1) ? $clog2(H_ACT) : 1;

    logic [PIX_W-1:0]      pix_q,  pix_d;
    logic [LINE_CNT_W-1:0] line_q, line_d;
    logic                  last_pix, last_line;

    assign last_pix  = (pix_q  == PIX_W'(H_ACT - 1));
    assign last_line = (line_q == LINE_CNT_W'(V_ACT - 1));

    always_comb begin
        pix_d  = pix_q;
        line_d = line_q;
        if (en_i) begin
            if (last_pix) begin
                pix_d  = '0;
                line_d = last_line ? '0 : line_q + 1'b1;
            end else begin
                pix_d  = pix_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pix_q  <= '0;
            line_q <= '0;
        end else begin
            pix_q  <= pix_d;
            line_q <= line_d;
        end
    end

    assign line_cnt_o   = line_q;
    assign frame_done_o = en_i & last_pix & last_line;

endmodule

// File: rtl/field_read_scheduler.sv
// -----------------------------------------------------------------------------
// field_read_scheduler
// Sequences the odd/even field SDRAM read FIFOs against the VGA pixel-request
// stream: FIFO reload at frame boundaries, per-field read enables, line-buffer
// clock enable and a registered, field-muxed pixel word (blank on underflow).
// Ports:
//   clock, aresetn : pixel clock, asynchronous active-low reset
//   bus (slave)    : pix_ready, rd1/rd2 data+empty in; rd1_req, rd2_req,
//                    rd_load, lb_clken, pix_data, pix_valid, line_cnt,
//                    underflow_cnt, sched_state out
// Build option:
//   FIELD_SCHED_UFLOW_CNT_EN : when defined, underflow_cnt is a saturating
//   count of ready cycles that found the selected FIFO empty; otherwise it is
//   tied to 0 (blank substitution still happens).
// -----------------------------------------------------------------------------
module field_read_scheduler
    import field_sched_pkg::*;
#(
    parameter int                    H_ACT       = 640,
    parameter int                    V_ACT       = 480,
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    LOAD_CYCLES = 4,
    parameter logic [DATA_WIDTH-1:0] BLANK_WORD  = DATA_WIDTH'(BLANK_WORD_DEFAULT),
    parameter int                    UFLOW_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  aresetn,
    field_read_scheduler_if.slave bus
);

    localparam int TIMER_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

    sched_state_e          state_q, state_d;
    logic [TIMER_W-1:0]    load_timer_q, load_timer_d;
    logic [DATA_WIDTH-1:0] pix_data_q, pix_data_d;
    logic                  pix_valid_q, pix_valid_d;
    logic [LINE_CNT_W-1:0] line_cnt;
    logic                  frame_done;
    logic                  sel_field2;
    logic                  sel_empty;
    logic                  stream_cycle;

    // The first ready cycle seen in WAIT is already pixel 0 of line 0, so it
    // is a full streaming cycle (read, count, output) just like STREAM.
    assign stream_cycle = bus.pix_ready & ((state_q == S_STREAM) | (state_q == S_WAIT));
    assign sel_field2   = line_cnt[0];
    assign sel_empty    = sel_field2 ? bus.rd2_empty : bus.rd1_empty;

    raster_counter #(
        .H_ACT (H_ACT),
        .V_ACT (V_ACT)
    ) u_raster (
        .clk_i        (clock),
        .rst_ni       (aresetn),
        .en_i         (stream_cycle),
        .line_cnt_o   (line_cnt),
        .frame_done_o (frame_done)
    );

    always_comb begin
        state_d      = state_q;
        load_timer_d = load_timer_q;
        case (state_q)
            S_LOAD: begin
                // Requests arriving before the reload completes are an error.
                if (bus.pix_ready) begin
                    state_d      = S_ERR;
                    load_timer_d = '0;
                end else if (load_timer_q == TIMER_W'(LOAD_CYCLES - 1)) begin
                    state_d      = S_WAIT;
                    load_timer_d = '0;
                end else begin
                    load_timer_d = load_timer_q + 1'b1;
                end
            end
            S_WAIT, S_STREAM: begin
                if (stream_cycle) state_d = frame_done ? S_LOAD : S_STREAM;
            end
            S_ERR: begin
                if (!bus.pix_ready) state_d = S_LOAD;
            end
            default: state_d = S_LOAD;
        endcase

        pix_valid_d = stream_cycle | (bus.pix_ready & (state_q == S_ERR));
        pix_data_d  = BLANK_WORD;
        if (stream_cycle && !sel_empty) pix_data_d = sel_field2 ? bus.rd2_data : bus.rd1_data;
    end

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= S_LOAD;
            load_timer_q <= '0;
            pix_data_q   <= BLANK_WORD;
            pix_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_timer_q <= load_timer_d;
            pix_data_q   <= pix_data_d;
            pix_valid_q  <= pix_valid_d;
        end
    end

`ifdef FIELD_SCHED_UFLOW_CNT_EN
    logic [UFLOW_WIDTH-1:0] uflow_q, uflow_d;

    always_comb begin
        uflow_d = uflow_q;
        if (stream_cycle && sel_empty && (uflow_q != {UFLOW_WIDTH{1'b1}})) uflow_d = uflow_q + 1'b1;
    end

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) uflow_q <= '0;
        else          uflow_q <= uflow_d;
    end

    assign bus.underflow_cnt = uflow_q;
`else
    assign bus.underflow_cnt = {UFLOW_WIDTH{1'b0}};
`endif

    // Requests are issued even when the selected FIFO is empty; the FIFO
    // ignores a read while empty.
    assign bus.rd1_req     = stream_cycle & ~sel_field2;
    assign bus.rd2_req     = stream_cycle &  sel_field2;
    // Gated by reset so rd_load reads 0 while aresetn is held low.
    assign bus.rd_load     = aresetn & (state_q == S_LOAD);
    assign bus.lb_clken    = stream_cycle | (bus.pix_ready & (state_q == S_ERR));
    assign bus.pix_data    = pix_data_q;
    assign bus.pix_valid   = pix_valid_q;
    assign bus.line_cnt    = line_cnt;
    assign bus.sched_state = state_q;

endmodule

// File: tb/tb_field_read_scheduler.sv
module tb_field_read_scheduler;
  import field_sched_pkg::*;

  localparam int H  = 16;
  localparam int V  = 4;
  localparam int DW = 16;
  localparam int UW = 16;
  localparam int LC = 4;
  localparam logic [DW-1:0] BLANK = 16'h8010;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic aresetn = 1'b1;
  always #5 clock = ~clock;

  field_read_scheduler_if #(.DATA_WIDTH(DW), .UFLOW_WIDTH(UW)) bus();

  field_read_scheduler #(
    .H_ACT(H), .V_ACT(V), .DATA_WIDTH(DW), .LOAD_CYCLES(LC),
    .BLANK_WORD(BLANK), .UFLOW_WIDTH(UW)
  ) dut (
    .clock   (clock),
    .aresetn (aresetn),
    .bus     (bus)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int passes = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mon_exp;
  int m_pix = 0;
  int m_line = 0;
  int m_uflow = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] exp_uflow();
`ifdef FIELD_SCHED_UFLOW_CNT_EN
    return m_uflow;
`else
    return 0;
`endif
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (bus.pix_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL pix_unexpected: got pix_valid=1 data %0h expected no word at %0t", bus.pix_data, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pix_data", bus.pix_data, mon_exp);
      end
    end else begin
      check("pix_idle_blank", bus.pix_data, BLANK);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_ready(input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                             input logic e1, input logic e2);
    logic sel2;
    logic [DW-1:0] e;
    @(posedge clock); #1;
    bus.pix_ready = 1'b1;
    bus.rd1_data  = d1;
    bus.rd2_data  = d2;
    bus.rd1_empty = e1;
    bus.rd2_empty = e2;
    sel2 = m_line[0];
    if (sel2) e = e2 ? BLANK : d2;
    else      e = e1 ? BLANK : d1;
    exp_q.push_back(e);
    if ((sel2 && e2) || (!sel2 && e1)) m_uflow++;
    @(negedge clock);
    check("rd1_req", bus.rd1_req, !sel2);
    check("rd2_req", bus.rd2_req, sel2);
    check("rd_load_in_stream", bus.rd_load, 0);
    check("lb_clken_stream", bus.lb_clken, 1);
    m_pix++;
    if (m_pix == H) begin
      m_pix = 0;
      m_line++;
      if (m_line == V) m_line = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      bus.pix_ready = 1'b0;
      bus.rd1_empty = 1'b0;
      bus.rd2_empty = 1'b0;
      @(negedge clock);
      check("idle_rd1_req", bus.rd1_req, 0);
      check("idle_rd2_req", bus.rd2_req, 0);
      check("idle_lb_clken", bus.lb_clken, 0);
    end
  endtask

  // Samples rd_load on the next n falling edges with pix_ready held low.
  task automatic count_load(input int n, input string name);
    int hits;
    hits = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (bus.rd_load === 1'b1) hits++;
    end
    check(name, hits, LC);
    check({name, "_state_wait"}, bus.sched_state, 1);
    check({name, "_rd1_req"}, bus.rd1_req, 0);
    check({name, "_rd2_req"}, bus.rd2_req, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.pix_ready = 1'b0;
    bus.rd1_data  = '0;
    bus.rd2_data  = '0;
    bus.rd1_empty = 1'b0;
    bus.rd2_empty = 1'b0;
    #1 aresetn = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_state", bus.sched_state, 0);
    check("rst_rd_load", bus.rd_load, 0);
    check("rst_rd1_req", bus.rd1_req, 0);
    check("rst_pix_valid", bus.pix_valid, 0);
    check("rst_pix_data", bus.pix_data, BLANK);
    check("rst_line_cnt", bus.line_cnt, 0);
    check("rst_uflow", bus.underflow_cnt, 0);

    // Release: reload pulse of exactly LC clocks, then WAIT.
    @(posedge clock); #1 aresetn = 1'b1;
    count_load(8, "load_after_reset");

    // Line 0: odd field, constant word.
    for (int i = 0; i < H; i++) drive_ready(16'h1234, 16'hABCD, 1'b0, 1'b0);
    idle(1);
    check("line0_done_line_cnt", bus.line_cnt, 1);
    check("line0_done_state", bus.sched_state, 2);

    // Line 1: even field, first 10 words underflow.
    for (int i = 0; i < 10; i++) drive_ready(16'h1234, 16'hABCD, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) drive_ready(16'h1234, 16'hAB00 + 16'(i), 1'b0, 1'b0);
    idle(3);
    check("line1_done_line_cnt", bus.line_cnt, 2);
    check("uflow_after_line1", bus.underflow_cnt, exp_uflow());

    // Line 2 with a blanking gap in the middle: counters must freeze.
    for (int i = 0; i < 8; i++) drive_ready(16'h5500 + 16'(i), 16'h0F0F, 1'b0, 1'b0);
    idle(4);
    check("gap_line_cnt", bus.line_cnt, 2);
    check("gap_state", bus.sched_state, 2);
    for (int i = 0; i < 8; i++) drive_ready(16'h5600 + 16'(i), 16'h0F0F, 1'b0, 1'b0);

    // Line 3: last line; the frame ends on its final pixel.
    for (int i = 0; i < H; i++) drive_ready(16'h2222, 16'h7700 + 16'(i), 1'b0, 1'b0);
    @(posedge clock); #1 bus.pix_ready = 1'b0;
    @(negedge clock);
    check("frame_end_rd_load", bus.rd_load, 1);
    check("frame_end_line_cnt", bus.line_cnt, 0);
    check("frame_end_state", bus.sched_state, 0);

    // Ready while reloading -> ERR: blank words, no FIFO reads.
    @(posedge clock); #1;
    bus.pix_ready = 1'b1;
    bus.rd1_data  = 16'h1234;
    @(negedge clock);
    check("early_ready_state_load", bus.sched_state, 0);
    check("early_ready_rd1_req", bus.rd1_req, 0);
    check("early_ready_lb_clken", bus.lb_clken, 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clock); #1;
      bus.pix_ready = 1'b1;
      exp_q.push_back(BLANK);
      @(negedge clock);
      check("err_state", bus.sched_state, 3);
      check("err_rd1_req", bus.rd1_req, 0);
      check("err_rd2_req", bus.rd2_req, 0);
      check("err_rd_load", bus.rd_load, 0);
      check("err_lb_clken", bus.lb_clken, 1);
    end
    @(posedge clock); #1 bus.pix_ready = 1'b0;
    count_load(8, "load_after_err");

    // Stream into line 2, then reset mid-frame asynchronously.
    for (int i = 0; i < 2 * H + 5; i++) drive_ready(16'h3000 + 16'(i), 16'h3100 + 16'(i), 1'b0, 1'b0);
    @(posedge clock); #1 bus.pix_ready = 1'b0;
    @(negedge clock);
    check("pre_reset_line_cnt", bus.line_cnt, 2);
    #2 aresetn = 1'b0;
    #1;
    check("async_rst_state", bus.sched_state, 0);
    check("async_rst_line_cnt", bus.line_cnt, 0);
    check("async_rst_rd_load", bus.rd_load, 0);
    check("async_rst_pix_valid", bus.pix_valid, 0);
    check("async_rst_pix_data", bus.pix_data, BLANK);
    check("async_rst_uflow", bus.underflow_cnt, 0);
    m_pix = 0;
    m_line = 0;
    m_uflow = 0;
    @(posedge clock); #1 aresetn = 1'b1;
    count_load(8, "load_after_midframe_reset");

    // Restart from line 0 on the odd field.
    for (int i = 0; i < 3; i++) drive_ready(16'h4400 + 16'(i), 16'h4500, 1'b0, 1'b0);
    idle(2);
    check("restart_line_cnt", bus.line_cnt, 0);
    check("exp_q_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/field_read_scheduler.md
Name: field_read_scheduler

Overview:
- Sequences the two SDRAM frame-buffer read FIFOs (odd field and even field) against the VGA pixel-request stream.
- Generates per-field read enables, FIFO reload pulses at frame boundaries, the line-buffer clock enable, and a registered, field-muxed pixel word.
- Substitutes a blank word when a FIFO underflows.
- Sits between vga_sync (ready output) and Sdram_Control_4Port read ports 1/2. It replaces the ad-hoc field-select muxing around them.

Parameters:
- H_ACT, 640, active pixels per line (pix_ready cycles per line)
- V_ACT, 480, active lines per frame
- DATA_WIDTH, 16, YCbCr word width
- LOAD_CYCLES, 4, length of the rd*_load pulse in clocks (≥1)
- BLANK_WORD, 16'h8010, word output on underflow or outside STREAM
- UFLOW_WIDTH, 16, underflow counter width

Ports:
- clock  in  1  pixel clock (TD_CLK27 domain)
- aresetn  in  1  asynchronous active-low reset
- pix_ready  in  1  VGA pixel request, one word consumed per high cycle
- rd1_data  in  DATA_WIDTH  odd-field FIFO data
- rd1_empty  in  1  odd-field FIFO empty
- rd2_data  in  DATA_WIDTH  even-field FIFO data
- rd2_empty  in  1  even-field FIFO empty
- rd1_req  out  1  odd-field FIFO read enable
- rd2_req  out  1  even-field FIFO read enable
- rd_load  out  1  reload pulse to both read FIFOs (RD1_LOAD/RD2_LOAD)
- lb_clken  out  1  line-buffer shift enable
- pix_data  out  DATA_WIDTH  muxed pixel word, registered
- pix_valid  out  1  pix_data valid
- line_cnt  out  10  current active line index
- underflow_cnt  out  UFLOW_WIDTH  saturating underflow count
- sched_state  out  2  FSM state for debug

Behaviour:
- Reset values (async, aresetn=0):
  - state=LOAD, load_timer=0, pix_cnt=0, line_cnt=0, underflow_cnt=0
  - all other outputs 0; pix_data=BLANK_WORD
- FSM states and encodings: LOAD=0, WAIT=1, STREAM=2, ERR=3.
  - LOAD: rd_load=1 for exactly LOAD_CYCLES clocks, then go to WAIT.
  - WAIT: on the first cycle with pix_ready=1, go to STREAM. That cycle is consumed as pixel 0 of line 0.
  - STREAM: on each pix_ready=1 cycle, pix_cnt++.
    - When pix_cnt==H_ACT-1 on a ready cycle, pix_cnt←0 and line_cnt++.
    - When line_cnt==V_ACT-1 with pix_cnt==H_ACT-1 on a ready cycle, go to LOAD (frame done), clearing both counters.
  - ERR: entered from LOAD when pix_ready=1 (requests arrived before reload finished).
    - Behaves as STREAM for outputs, but with blank data and no FIFO reads.
    - Returns to LOAD on the next cycle with pix_ready=0.
- Field select uses line_cnt[0]: 0 selects FIFO1 (odd field), 1 selects FIFO2.
- Read enables:
  - rd1_req = (state==STREAM) & pix_ready & ~line_cnt[0]
  - rd2_req = (state==STREAM) & pix_ready & line_cnt[0]
  - Both are combinational, same cycle as pix_ready, and mutually exclusive.
  - A request is still issued when the selected FIFO is empty (FIFO ignores it).
- lb_clken = pix_ready in STREAM and ERR; 0 in LOAD and WAIT.
- Pixel output has 1-cycle latency:
  - pix_valid(t+1) = pix_ready(t) & state∈{STREAM,ERR}
  - pix_data(t+1) = selected rd*_data(t) if selected FIFO not empty and state==STREAM; otherwise BLANK_WORD
  - When pix_valid=0, pix_data holds BLANK_WORD.
- Underflow: a STREAM ready cycle whose selected FIFO has empty=1 increments underflow_cnt. The count saturates at all-ones and does not clear at frame boundaries (reset only).
- Transition boundaries:
  - In the WAIT→STREAM transition cycle, rd1_req is asserted (line 0, pix 0).
  - The last frame pixel is read normally; rd_load rises the next cycle.
- Gaps in pix_ready (horizontal/vertical blanking) freeze the counters.
- Reset mid-frame: all state is cleared immediately and the scheduler restarts at LOAD, forcing a FIFO reload.

Optional Feature:
- FIELD_SCHED_UFLOW_CNT_EN
  - Defined: underflow_cnt behaves as above.
  - Undefined: the counter is not built and underflow_cnt is tied to 0. BLANK_WORD substitution on underflow remains.

Decomposition:
- Package field_sched_pkg holds:
  - state enum with encodings LOAD/WAIT/STREAM/ERR
  - default BLANK_WORD constant
  - line_cnt width constant (10)
- One natural sub-module, raster_counter: pix_cnt/line_cnt with enable, H_ACT/V_ACT wrap and a frame_done pulse. It is instantiated once.

Test Plan:
- Reset release, pix_ready=0 → rd_load high for exactly 4 cycles, then sched_state=1 and all req low.
- Then pix_ready high 640 cycles, FIFOs non-empty with rd1_data=16'h1234 → rd1_req high for 640 cycles, rd2_req=0, pix_data=16'h1234 one cycle later, line_cnt=1 after.
- Second line → only rd2_req toggles. Full 640×480 ready stream → rd_load pulse starts the cycle after the 307200th ready, line_cnt returns to 0.
- rd2_empty=1 for 10 ready cycles on line 1 → pix_data=16'h8010 for those cycles, underflow_cnt=10 (0 with macro undefined).
- pix_ready asserted during LOAD → sched_state=3, no rd*_req, pix_data=BLANK_WORD; drop pix_ready → LOAD re-entered, 4-cycle rd_load.
- aresetn pulsed low at line 200 → outputs reset asynchronously, line_cnt=0, rd_load restarts after release.
